// File: rtl/barreira_led_multicanal.sv
// ---------------------------------------------------------------------------
// barreira_led_multicanal
//
// Multi-channel light-barrier LED driver. Each raw sensor line is brought into
// the clock domain with a two-flop synchroniser and then debounced. The
// debounced state drives one LED per channel in a run-time selectable mode.
// The block also emits per-channel rising-edge pulses and a saturating global
// count of accepted detections.
//
// Ports
//   clk           system clock, everything on the rising edge
//   rst           synchronous, active-high reset
//   objeto_perto  [N_CANAIS]  raw asynchronous sensor lines, 1 = object near
//   modo          [2]         LED mode for all channels:
//                             00 direct, 01 blink, 10 latched alarm, 11 inverted
//   limpar        one-cycle pulse, clears the alarm latches and the counter
//   led           [N_CANAIS]  registered LED drive
//   detectado     [N_CANAIS]  registered debounced channel state
//   evento        [N_CANAIS]  one-cycle pulse on a debounced 0->1 transition
//   contagem      [CONT_W]    saturating count of accepted 0->1 transitions
//
// Every registered output is derived from the *next* value of the debounced
// state, the latches and the blink phase. As a result led, evento and contagem
// change on the same edge as detectado, with no extra pipeline stage.
// ---------------------------------------------------------------------------
module barreira_led_multicanal #(
  parameter int N_CANAIS        = 4,
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int PISCA_CICLOS    = 3,
  parameter int CONT_W          = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CANAIS-1:0] objeto_perto,
  input  logic [1:0]          modo,
  input  logic                limpar,
  output logic [N_CANAIS-1:0] led,
  output logic [N_CANAIS-1:0] detectado,
  output logic [N_CANAIS-1:0] evento,
  output logic [CONT_W-1:0]   contagem
);

  // Debounce counter only needs to reach DEBOUNCE_CICLOS-1.
  localparam int DB_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CICLOS - 1);

  // Blink prescaler counts 0..PISCA_CICLOS-1.
  localparam int PS_W = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PISCA_CICLOS - 1);

  // Popcount of evento and the widened sum used for saturation.
  localparam int POP_W = $clog2(N_CANAIS + 1);
  localparam int SUM_W = ((CONT_W > POP_W) ? CONT_W : POP_W) + 1;
  localparam logic [CONT_W-1:0] CONT_MAX = {CONT_W{1'b1}};

  localparam logic [1:0] MODO_DIRETO   = 2'b00;
  localparam logic [1:0] MODO_PISCA    = 2'b01;
  localparam logic [1:0] MODO_TRAVADO  = 2'b10;
  localparam logic [1:0] MODO_INVERTIDO = 2'b11;

  // Shared state across channels
  logic [N_CANAIS-1:0] det_q, det_d;
  logic [N_CANAIS-1:0] latch_q, latch_d;
  logic [N_CANAIS-1:0] evento_q, evento_d;
  logic [N_CANAIS-1:0] led_q, led_d;
  logic [CONT_W-1:0]   contagem_q, contagem_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic                phase_q, phase_d;

  // -------------------------------------------------------------------------
  // Blink generator: free-running and independent of all inputs.
  // -------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q + 1'b1;
    phase_d = phase_q;
    if (presc_q == PS_MAX) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel synchroniser, debounce, latch and LED mode select.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CANAIS; gi++) begin : g_canal
      logic            s1_q, s2_q;
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            det_nx;
      logic            led_nx;

      // The counter only survives while s2 keeps disagreeing with the accepted
      // state. Any agreeing sample restarts it, so short glitches vanish.
      always_comb begin
        cnt_d  = '0;
        det_nx = det_q[gi];
        if (s2_q != det_q[gi]) begin
          if (cnt_q == DB_MAX) begin
            det_nx = ~det_q[gi];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q  <= objeto_perto[gi];
          s2_q  <= s1_q;
          cnt_q <= cnt_d;
        end
      end

      assign det_d[gi]    = det_nx;
      assign evento_d[gi] = det_nx & ~det_q[gi];
      // A new event wins over a simultaneous clear.
      assign latch_d[gi]  = evento_d[gi] | (latch_q[gi] & ~limpar);

      always_comb begin
        led_nx = 1'b0;
        case (modo)
          MODO_DIRETO:    led_nx = det_nx;
          MODO_PISCA:     led_nx = det_nx & phase_d;
          MODO_TRAVADO:   led_nx = latch_d[gi];
          MODO_INVERTIDO: led_nx = ~det_nx;
          default:        led_nx = 1'b0;
        endcase
      end

      assign led_d[gi] = led_nx;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Saturating detection counter. A clear reloads with this cycle's events,
  // so no detection is lost in the cycle the counter is cleared.
  // -------------------------------------------------------------------------
  logic [POP_W-1:0] pop_cnt;
  logic [SUM_W-1:0] soma;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N_CANAIS; i++) begin
      pop_cnt = pop_cnt + POP_W'(evento_d[i]);
    end
    if (limpar) begin
      soma = SUM_W'(pop_cnt);
    end else begin
      soma = SUM_W'(contagem_q) + SUM_W'(pop_cnt);
    end
    if (soma > SUM_W'(CONT_MAX)) begin
      contagem_d = CONT_MAX;
    end else begin
      contagem_d = soma[CONT_W-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Shared registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      det_q      <= '0;
      latch_q    <= '0;
      evento_q   <= '0;
      led_q      <= '0;
      contagem_q <= '0;
      presc_q    <= '0;
      phase_q    <= 1'b0;
    end else begin
      det_q      <= det_d;
      latch_q    <= latch_d;
      evento_q   <= evento_d;
      led_q      <= led_d;
      contagem_q <= contagem_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
    end
  end

  assign led       = led_q;
  assign detectado = det_q;
  assign evento    = evento_q;
  assign contagem  = contagem_q;

endmodule

// File: doc/barreira_led_multicanal.md
Name: barreira_led_multicanal

Overview:
Multi-channel successor to the single-LED light-barrier driver. It takes N raw "object near" sensor lines and, per channel, synchronises and debounces each one. It then drives one LED per channel in a run-time selectable mode: direct, blinking, latched alarm or inverted. It also produces per-channel detection pulses and a saturating global detection counter for the display/UART logic downstream.

Parameters:
N_CANAIS, 4, number of sensor/LED channels (>=1)
DEBOUNCE_CICLOS, 4, consecutive stable synchronised samples needed to accept a change (>=1)
PISCA_CICLOS, 3, clock cycles per blink half-period (>=1)
CONT_W, 4, width of the detection counter (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
objeto_perto  input  N_CANAIS  raw asynchronous sensor lines, 1 = object near
modo  input  2  LED mode, global to all channels: 00 direct, 01 blink, 10 latched, 11 inverted
limpar  input  1  one-cycle pulse that clears alarm latches and the counter
led  output  N_CANAIS  LED drive, registered
detectado  output  N_CANAIS  debounced channel state, registered
evento  output  N_CANAIS  one-cycle pulse on a debounced 0->1 transition
contagem  output  CONT_W  saturating count of accepted 0->1 transitions

Behaviour:
- Reset (rst=1 at an edge) clears everything: sync flops, debounce counters, detectado, latches, led, evento, contagem, blink prescaler and blink phase. led=0 after reset in every mode, including 11. Reset mid-debounce discards the partial count.
- Synchroniser: two flops per channel feeding an internal signal s2.
- Debounce, per channel:
  - At each edge where s2 != detectado, the counter increments.
  - When it is already DEBOUNCE_CICLOS-1, detectado flips and the counter clears instead.
  - At any edge where s2 == detectado, the counter clears.
  - Result: glitches shorter than DEBOUNCE_CICLOS synchronised cycles are ignored.
- Latency: an input step sampled at edge k (counted as edge 1) changes detectado after edge DEBOUNCE_CICLOS+2. That is 6 clocks with defaults.
- All other outputs are computed from the next value of detectado and update on the same edge. No extra latency.
- evento[i] is 1 for exactly one cycle, on the edge where detectado[i] goes 0->1. There is no pulse on 1->0.
- Latch[i] is set by evento[i] and cleared by limpar. Set wins if both occur in the same cycle. Latches track in every mode, so switching to mode 10 shows the accumulated alarms.
- Counter:
  - contagem += popcount(evento) each cycle, saturating at 2^CONT_W-1 with no wrap.
  - limpar loads popcount of the same-cycle evento, not 0.
- Blink generator:
  - The prescaler counts 0..PISCA_CICLOS-1 and wraps.
  - The phase toggles on each wrap; the phase is 0 after reset.
  - It runs continuously, independent of the inputs.
- led[i] by mode:
  - 00: detectado.
  - 01: detectado AND phase.
  - 10: latch.
  - 11: NOT detectado.
- A mode change is sampled like any input and is visible on led at the next edge.
- Channels are fully independent. Simultaneous transitions on several channels are each handled in the same cycle.

Test Plan:
1. Reset with modo=11 -> led=0000, contagem=0. First edge after rst release with objeto_perto=0 -> led=1111.
2. Defaults, modo=00, objeto_perto[0] 0->1 held -> detectado[0] and led[0] rise exactly 6 clocks later; evento[0] high for 1 cycle; contagem=1.
3. 3-cycle pulse on objeto_perto[1] (< DEBOUNCE_CICLOS) -> detectado, evento and contagem unchanged. A 4-cycle pulse -> accepted.
4. modo=01, channel 2 held detected -> led[2] alternates 3 cycles on / 3 cycles off in step with the phase; led[2]=0 whenever detectado[2]=0.
5. modo=10, channel 3 detect then release -> led[3] stays 1. limpar -> led[3]=0 next edge. limpar coinciding with a new evento[3] -> led[3] stays 1 and contagem=1.
6. Drive 20 accepted rising transitions on 4 channels, including simultaneous ones -> contagem stops at 15 and does not wrap. All 4 channels rising in one cycle from contagem=13 -> 15.
